if_id_seg: RTL and testbench

IF_ID_SEG -- requirements
Module: if_id_seg

---
 rtl/if_id_seg.sv | 121 ++++++++++++
 tb/tb_if_id_seg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_seg.sv
// IF/ID pipeline register with bubble/flush injection and EMPTY/VALID/HELD tracking (optional perf counters: IF_ID_PERF_CNT_EN).
// Latency: 1 cycle from a qualifying clk edge to outputs; outputs come only from flops.
// Backpressure: stall holds contents (flush overrides it); en=0 freezes every register including counters.
module if_id_seg #(
    parameter logic [31:0] NOP_INST = 32'h00000013,
    parameter logic [31:0] RST_PC   = 32'h00400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_if,
    input  logic [31:0] inst_if,
    output logic [31:0] pc_id,
    output logic [31:0] pcadd4_id,
    output logic [31:0] inst_id,
    output logic        valid_id,
    output logic [1:0]  state_id
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_VALID = 2'd1,
        S_HELD  = 2'd2,
        S_BAD   = 2'd3
    } state_t;

    localparam logic [31:0] RST_PCADD4 = RST_PC + 32'd4;

    // Declaration initialisers give power-up values equal to the reset values.
    state_t      state_q  = S_EMPTY;
    logic [31:0] pc_q     = RST_PC;
    logic [31:0] pcadd4_q = RST_PCADD4;
    logic [31:0] inst_q   = NOP_INST;
    logic        valid_q  = 1'b0;

    state_t      state_n;
    logic [31:0] pc_n;
    logic [31:0] pcadd4_n;
    logic [31:0] inst_n;
    logic        valid_n;

    // Next-state and next-data selection: rst > illegal-state recovery > !en > flush > stall > load.
    always_comb begin
        state_n  = state_q;
        pc_n     = pc_q;
        pcadd4_n = pcadd4_q;
        inst_n   = inst_q;
        valid_n  = valid_q;
        if (rst || state_q == S_BAD || (en && flush)) begin
            // Encoding 3 is never produced; if it shows up, recover as a flush.
            state_n  = S_EMPTY;
            pc_n     = RST_PC;
            pcadd4_n = RST_PCADD4;
            inst_n   = NOP_INST;
            valid_n  = 1'b0;
        end else if (en && stall) begin
            // Data holds; only a live instruction is marked HELD, an empty slot stays EMPTY.
            if (valid_q) begin
                state_n = S_HELD;
            end
        end else if (en) begin
            state_n  = S_VALID;
            pc_n     = pc_if;
            pcadd4_n = pc_if + 32'd4;
            inst_n   = inst_if;
            valid_n  = 1'b1;
        end
    end

    // Pipeline register update.
    always_ff @(posedge clk) begin
        state_q  <= state_n;
        pc_q     <= pc_n;
        pcadd4_q <= pcadd4_n;
        inst_q   <= inst_n;
        valid_q  <= valid_n;
    end

    assign pc_id     = pc_q;
    assign pcadd4_id = pcadd4_q;
    assign inst_id   = inst_q;
    assign valid_id  = valid_q;
    assign state_id  = state_q;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q = 32'd0;
    logic [31:0] flush_cnt_q = 32'd0;
    logic        stall_inc;
    logic        flush_inc;

    // Only stalls that actually hold a real instruction are counted.
    assign stall_inc = en && !flush && stall && valid_q;
    assign flush_inc = en && flush;

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_inc && stall_cnt_q != 32'hFFFFFFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_inc && flush_cnt_q != 32'hFFFFFFFF) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_seg.sv
// Self-checking bench for if_id_seg: reference model plus per-cycle compare and hand-computed literal points.
// Latency: model state advances on each rising edge; compare runs on falling edges.
// Backpressure: stimulus exercises stall, flush, en=0 and reset-during-stall.
module tb_if_id_seg;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] RPC = 32'h00400000;

    logic        clk;
    logic        rst     = 1'b1;
    logic        en      = 1'b0;
    logic        stall   = 1'b0;
    logic        flush   = 1'b0;
    logic [31:0] pc_if   = 32'd0;
    logic [31:0] inst_if = 32'd0;
    logic [31:0] pc_id;
    logic [31:0] pcadd4_id;
    logic [31:0] inst_id;
    logic        valid_id;
    logic [1:0]  state_id;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    if_id_seg #(.NOP_INST(NOP), .RST_PC(RPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .stall     (stall),
        .flush     (flush),
        .pc_if     (pc_if),
        .inst_if   (inst_if),
        .pc_id     (pc_id),
        .pcadd4_id (pcadd4_id),
        .inst_id   (inst_id),
        .valid_id  (valid_id),
        .state_id  (state_id)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt_o),
        .flush_cnt (flush_cnt_o)
`endif
    );

`ifndef IF_ID_PERF_CNT_EN
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

    // Clock starts high so the first falling edge precedes any rising edge (power-up check).
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: what the ID slot holds, whether it is being held, and event counts.
    logic [31:0] m_pc    = RPC;
    logic [31:0] m_inst  = NOP;
    bit          m_valid = 1'b0;
    bit          m_held  = 1'b0;
    logic [31:0] m_sc    = 32'd0;
    logic [31:0] m_fc    = 32'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = RPC; m_inst = NOP; m_valid = 0; m_held = 0; m_sc = 0; m_fc = 0;
        end else if (en) begin
            if (flush) begin
                if (m_fc != 32'hFFFFFFFF) m_fc = m_fc + 1;
                m_pc = RPC; m_inst = NOP; m_valid = 0; m_held = 0;
            end else if (stall) begin
                if (m_valid) begin
                    if (m_sc != 32'hFFFFFFFF) m_sc = m_sc + 1;
                    m_held = 1;
                end
            end else begin
                m_pc = pc_if; m_inst = inst_if; m_valid = 1; m_held = 0;
            end
        end
    end

    // Literal expectations posted by the stimulus, consumed by the compare process.
    string       lit_name;
    logic [31:0] lit_pc, lit_p4, lit_inst, lit_sc, lit_fc;
    logic        lit_v;
    logic [1:0]  lit_st;
    int          lit_seq = 0;
    int          seen_seq = 0;

    task automatic lit(input string name, input logic [31:0] pc, input logic [31:0] p4,
                       input logic [31:0] inst, input logic v, input logic [1:0] st,
                       input logic [31:0] sc, input logic [31:0] fc);
        lit_name = name; lit_pc = pc; lit_p4 = p4; lit_inst = inst;
        lit_v = v; lit_st = st; lit_sc = sc; lit_fc = fc;
        lit_seq = lit_seq + 1;
    endtask

    // Compare process: model every cycle, plus any pending literal point.
    always @(negedge clk) begin
        logic [31:0] e_p4;
        logic [1:0]  e_st;
        bit          bad;
        e_p4 = m_pc + 32'd4;
        e_st = !m_valid ? 2'd0 : (m_held ? 2'd2 : 2'd1);
        bad = (pc_id !== m_pc) || (pcadd4_id !== e_p4) || (inst_id !== m_inst) ||
              (valid_id !== m_valid) || (state_id !== e_st);
`ifdef IF_ID_PERF_CNT_EN
        bad = bad || (stall_cnt_o !== m_sc) || (flush_cnt_o !== m_fc);
`endif
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL model t=%0t got pc=%h p4=%h inst=%h v=%b st=%0d sc=%0d fc=%0d want pc=%h p4=%h inst=%h v=%b st=%0d sc=%0d fc=%0d",
                     $time, pc_id, pcadd4_id, inst_id, valid_id, state_id, stall_cnt_o, flush_cnt_o,
                     m_pc, e_p4, m_inst, m_valid, e_st, m_sc, m_fc);
        end
        if (lit_seq != seen_seq) begin
            seen_seq = lit_seq;
            bad = (pc_id !== lit_pc) || (pcadd4_id !== lit_p4) || (inst_id !== lit_inst) ||
                  (valid_id !== lit_v) || (state_id !== lit_st);
`ifdef IF_ID_PERF_CNT_EN
            bad = bad || (stall_cnt_o !== lit_sc) || (flush_cnt_o !== lit_fc);
`endif
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s got pc=%h p4=%h inst=%h v=%b st=%0d sc=%0d fc=%0d want pc=%h p4=%h inst=%h v=%b st=%0d sc=%0d fc=%0d",
                         lit_name, pc_id, pcadd4_id, inst_id, valid_id, state_id, stall_cnt_o, flush_cnt_o,
                         lit_pc, lit_p4, lit_inst, lit_v, lit_st, lit_sc, lit_fc);
            end
        end
    end

    // Apply one cycle of inputs, return just after the rising edge.
    task automatic step(input logic r, input logic e, input logic s, input logic f,
                        input logic [31:0] pc, input logic [31:0] inst);
        rst = r; en = e; stall = s; flush = f; pc_if = pc; inst_if = inst;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        e, s, f;
        logic [31:0] pc, inst;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1, 0, 0, 32'h00400200, 32'h00100093};
        vecs[1]  = '{1, 1, 0, 32'h00400204, 32'h00200113};
        vecs[2]  = '{1, 1, 0, 32'h00400208, 32'h00300193};
        vecs[3]  = '{1, 0, 0, 32'h0040020C, 32'h00400213};
        vecs[4]  = '{0, 0, 0, 32'h00400210, 32'h00500293};
        vecs[5]  = '{0, 0, 1, 32'h00400214, 32'h00600313};
        vecs[6]  = '{1, 0, 1, 32'h00400218, 32'h00700393};
        vecs[7]  = '{1, 1, 0, 32'h0040021C, 32'h00800413};
        vecs[8]  = '{1, 0, 0, 32'h80000000, 32'hDEADBEEF};
        vecs[9]  = '{1, 1, 1, 32'h00400224, 32'h00A00513};
        vecs[10] = '{1, 0, 0, 32'hFFFFFFF8, 32'h12345678};
        vecs[11] = '{1, 0, 0, 32'h00000000, 32'h00000000};

        step(1, 1, 1, 0, 32'h11111110, 32'hAAAAAAAA);
        lit("reset", RPC, 32'h00400004, NOP, 0, 2'd0, 0, 0);
        step(0, 1, 0, 0, 32'h00400010, 32'h00500093);
        lit("load", 32'h00400010, 32'h00400014, 32'h00500093, 1, 2'd1, 0, 0);
        step(0, 1, 1, 0, 32'h00400014, 32'h00600113);
        lit("stall1", 32'h00400010, 32'h00400014, 32'h00500093, 1, 2'd2, 1, 0);
        step(0, 1, 1, 0, 32'h00400018, 32'h00700193);
        lit("stall2", 32'h00400010, 32'h00400014, 32'h00500093, 1, 2'd2, 2, 0);
        step(0, 1, 1, 0, 32'h0040001C, 32'h00800213);
        lit("stall3", 32'h00400010, 32'h00400014, 32'h00500093, 1, 2'd2, 3, 0);
        step(0, 1, 1, 1, 32'h00400020, 32'h00900293);
        lit("flush_over_stall", RPC, 32'h00400004, NOP, 0, 2'd0, 3, 1);
        step(0, 0, 0, 1, 32'h00400020, 32'h00A00313);
        lit("disable", RPC, 32'h00400004, NOP, 0, 2'd0, 3, 1);
        step(0, 1, 1, 0, 32'h00400024, 32'h00B00393);
        lit("stall_empty", RPC, 32'h00400004, NOP, 0, 2'd0, 3, 1);
        step(0, 1, 0, 0, 32'hFFFFFFFC, 32'h00000033);
        lit("wrap", 32'hFFFFFFFC, 32'h00000000, 32'h00000033, 1, 2'd1, 3, 1);
        step(0, 1, 0, 0, 32'h00400100, 32'h00A00113);
        lit("load2", 32'h00400100, 32'h00400104, 32'h00A00113, 1, 2'd1, 3, 1);
        step(0, 1, 1, 0, 32'h00400104, 32'h00B00193);
        lit("held2", 32'h00400100, 32'h00400104, 32'h00A00113, 1, 2'd2, 4, 1);
        step(1, 1, 1, 0, 32'h00400108, 32'h00C00213);
        lit("rst_mid_stall", RPC, 32'h00400004, NOP, 0, 2'd0, 0, 0);
        step(0, 1, 1, 0, 32'h0040010C, 32'h00D00293);
        lit("after_rst_stall", RPC, 32'h00400004, NOP, 0, 2'd0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            step(0, vecs[i].e, vecs[i].s, vecs[i].f, vecs[i].pc, vecs[i].inst);
        end
        lit("last_load", 32'h00000000, 32'h00000004, 32'h00000000, 1, 2'd1, 2, 2);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
